// File: rtl/eqn_seq_cmp_amisha_pkg.sv
// Shared types and elaboration helpers for the
// slice-serial magnitude comparator.
package eq_cmp_pkg_amisha;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslice_f(int w, int s);
    return (s >= 1) ? (w / s) : 1;
  endfunction

  function automatic int idx_w_f(int w, int s);
    int n;
    n = nslice_f(w, s);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(int w, int s);
    if (s < 1 || w < 1) return 1'b0;
    return (w % s) == 0;
  endfunction

endpackage

// File: rtl/eqn_seq_cmp_amisha_slice.sv
// Combinational SLICE-bit comparator: XNOR equality
// cells plus an MS-first greater-than priority chain.
module eq_slice_amisha
  import eq_cmp_pkg_amisha::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             slice_eq,
  output logic             slice_gt
);

  logic [SLICE-1:0] bit_eq;

  for (genvar i = 0; i < SLICE; i++) begin : g_cell
    assign bit_eq[i] = ~(a[i] ^ b[i]);
  end

  assign slice_eq = &bit_eq;

  // First differing bit from the top decides the direction.
  always_comb begin
    logic hit;
    hit      = 1'b0;
    slice_gt = 1'b0;
    for (int i = SLICE - 1; i >= 0; i--) begin
      if (!hit && !bit_eq[i]) begin
        slice_gt = a[i];
        hit      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eqn_seq_cmp_amisha.sv
// Multi-cycle unsigned comparator: walks the operands
// SLICE bits per clock, MS slice first.
module eqn_seq_cmp_amisha
  import eq_cmp_pkg_amisha::*;
#(
  parameter int WIDTH      = 16,
  parameter int SLICE      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk_amisha,
  input  logic             reset_amisha,
  input  logic             start_amisha,
  input  logic [WIDTH-1:0] a_amisha,
  input  logic [WIDTH-1:0] b_amisha,
  output logic             busy_amisha,
  output logic             done_amisha,
  output logic             eq_amisha,
  output logic             gt_amisha,
  output logic             lt_amisha
);

  localparam int NSLICE = nslice_f(WIDTH, SLICE);
  localparam int IDX_W  = idx_w_f(WIDTH, SLICE);
  localparam bit EE     = (EARLY_EXIT != 0);

  if (!params_ok(WIDTH, SLICE)) begin : g_bad_params
    $error("eqn_seq_cmp_amisha: SLICE must divide WIDTH");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [IDX_W-1:0] idx;
  logic             found;
  logic             s_eq;
  logic             s_gt;
  logic             last;

  eq_slice_amisha #(.SLICE(SLICE)) u_slice (
    .a        (a_sr[WIDTH-1 -: SLICE]),
    .b        (b_sr[WIDTH-1 -: SLICE]),
    .slice_eq (s_eq),
    .slice_gt (s_gt)
  );

  assign last = (idx == IDX_W'(NSLICE - 1));

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      state       <= IDLE;
      a_sr        <= '0;
      b_sr        <= '0;
      idx         <= '0;
      found       <= 1'b0;
      busy_amisha <= 1'b0;
      done_amisha <= 1'b0;
      eq_amisha   <= 1'b0;
      gt_amisha   <= 1'b0;
      lt_amisha   <= 1'b0;
    end else begin
      done_amisha <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_amisha) begin
            a_sr        <= a_amisha;
            b_sr        <= b_amisha;
            idx         <= '0;
            found       <= 1'b0;
            eq_amisha   <= 1'b0;
            gt_amisha   <= 1'b0;
            lt_amisha   <= 1'b0;
            busy_amisha <= 1'b1;
            state       <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          a_sr <= a_sr << SLICE;
          b_sr <= b_sr << SLICE;
          if (!last) idx <= idx + IDX_W'(1);
          if (EE && !s_eq) begin
            gt_amisha   <= s_gt;
            lt_amisha   <= !s_gt;
            busy_amisha <= 1'b0;
            done_amisha <= 1'b1;
            state       <= DONE;
          end else begin
            // Sticky: only the first mismatching slice counts.
            if (!s_eq && !found) begin
              found     <= 1'b1;
              gt_amisha <= s_gt;
              lt_amisha <= !s_gt;
            end
            if (last) begin
              eq_amisha   <= !found && s_eq;
              busy_amisha <= 1'b0;
              done_amisha <= 1'b1;
              state       <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eqn_seq_cmp_amisha.sv
// Bench: three comparator configurations driven from a
// vector table and a few hand-written sequences.
module tb_eqn_seq_cmp_amisha;

  logic        clk = 1'b0;
  logic [2:0]  rst_v;
  logic [2:0]  start_v;
  logic [15:0] a_v [3];
  logic [15:0] b_v [3];
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [2:0]  eq_v;
  logic [2:0]  gt_v;
  logic [2:0]  lt_v;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         dut;
    logic [2:0] res;
    int         lat;
  } exp_t;

  typedef struct {
    int          dut;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  res;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vt[13];

  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_GT = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  always #5 clk = ~clk;

  eqn_seq_cmp_amisha #(.WIDTH(16), .SLICE(4), .EARLY_EXIT(1)) u_ee1 (
    .clk_amisha   (clk),
    .reset_amisha (rst_v[0]),
    .start_amisha (start_v[0]),
    .a_amisha     (a_v[0]),
    .b_amisha     (b_v[0]),
    .busy_amisha  (busy_v[0]),
    .done_amisha  (done_v[0]),
    .eq_amisha    (eq_v[0]),
    .gt_amisha    (gt_v[0]),
    .lt_amisha    (lt_v[0])
  );

  eqn_seq_cmp_amisha #(.WIDTH(16), .SLICE(4), .EARLY_EXIT(0)) u_ee0 (
    .clk_amisha   (clk),
    .reset_amisha (rst_v[1]),
    .start_amisha (start_v[1]),
    .a_amisha     (a_v[1]),
    .b_amisha     (b_v[1]),
    .busy_amisha  (busy_v[1]),
    .done_amisha  (done_v[1]),
    .eq_amisha    (eq_v[1]),
    .gt_amisha    (gt_v[1]),
    .lt_amisha    (lt_v[1])
  );

  eqn_seq_cmp_amisha #(.WIDTH(1), .SLICE(1), .EARLY_EXIT(1)) u_w1 (
    .clk_amisha   (clk),
    .reset_amisha (rst_v[2]),
    .start_amisha (start_v[2]),
    .a_amisha     (a_v[2][0]),
    .b_amisha     (b_v[2][0]),
    .busy_amisha  (busy_v[2]),
    .done_amisha  (done_v[2]),
    .eq_amisha    (eq_v[2]),
    .gt_amisha    (gt_v[2]),
    .lt_amisha    (lt_v[2])
  );

  function automatic logic [2:0] res_of(int d);
    return {eq_v[d], gt_v[d], lt_v[d]};
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_done(int d, int bound, output int lat);
    lat = -1;
    for (int k = 1; k <= bound; k++) begin
      @(posedge clk);
      #1;
      if (done_v[d]) begin
        lat = k;
        break;
      end
    end
  endtask

  // Drive start through edge E0; caller sits away from the edge.
  task automatic launch(int d, logic [15:0] av, logic [15:0] bv,
                        logic [2:0] r, int l, string nm);
    a_v[d]     = av;
    b_v[d]     = bv;
    start_v[d] = 1'b1;
    sb.push_back('{d, r, l});
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    chk({nm, "_busy"}, int'(busy_v[d]), 1);
  endtask

  task automatic finish_cmp(string nm);
    exp_t e;
    int   lat;
    e = sb.pop_front();
    wait_done(e.dut, 20, lat);
    chk({nm, "_lat"}, lat, e.lat);
    chk({nm, "_res"}, int'(res_of(e.dut)), int'(e.res));
  endtask

  task automatic drain(string nm, int d, logic [2:0] r);
    @(posedge clk);
    #1;
    chk({nm, "_done_pulse"}, int'(done_v[d]), 0);
    chk({nm, "_hold"}, int'(res_of(d)), int'(r));
  endtask

  initial begin
    int lat;

    vt[0]  = '{0, 16'hA5A5, 16'hA5A5, R_EQ, 4};
    vt[1]  = '{0, 16'h8000, 16'h0000, R_GT, 1};
    vt[2]  = '{0, 16'h1234, 16'h1235, R_LT, 4};
    vt[3]  = '{0, 16'h2000, 16'h1FFF, R_GT, 1};
    vt[4]  = '{0, 16'h0000, 16'hF000, R_LT, 1};
    vt[5]  = '{1, 16'h8000, 16'h0000, R_GT, 4};
    vt[6]  = '{1, 16'h2000, 16'h1FFF, R_GT, 4};
    vt[7]  = '{1, 16'h1234, 16'h1235, R_LT, 4};
    vt[8]  = '{1, 16'hA5A5, 16'hA5A5, R_EQ, 4};
    vt[9]  = '{2, 16'h0000, 16'h0000, R_EQ, 1};
    vt[10] = '{2, 16'h0001, 16'h0000, R_GT, 1};
    vt[11] = '{2, 16'h0000, 16'h0001, R_LT, 1};
    vt[12] = '{2, 16'h0001, 16'h0001, R_EQ, 1};

    rst_v   = 3'b111;
    start_v = 3'b000;
    for (int d = 0; d < 3; d++) begin
      a_v[d] = '0;
      b_v[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_outs%0d", d),
          int'({busy_v[d], done_v[d], res_of(d)}), 0);
    end
    rst_v = 3'b000;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      launch(vt[i].dut, vt[i].a, vt[i].b, vt[i].res, vt[i].lat, nm);
      finish_cmp(nm);
      drain(nm, vt[i].dut, vt[i].res);
    end

    // Start while busy must be ignored.
    launch(0, 16'h00FF, 16'h00FF, R_EQ, 4, "ign");
    @(posedge clk);
    #1;
    a_v[0]     = 16'hFFFF;
    b_v[0]     = 16'h0000;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    begin
      exp_t e;
      e = sb.pop_front();
      wait_done(0, 20, lat);
      chk("ign_lat", lat + 2, e.lat);
      chk("ign_res", int'(res_of(0)), int'(e.res));
    end
    drain("ign", 0, R_EQ);

    // Asynchronous reset mid-compare.
    launch(0, 16'hFFFF, 16'hFFFF, R_EQ, 4, "rst");
    @(posedge clk);
    #3;
    rst_v[0] = 1'b1;
    #1;
    chk("rst_async", int'({busy_v[0], done_v[0], res_of(0)}), 0);
    void'(sb.pop_front());
    @(negedge clk);
    rst_v[0] = 1'b0;
    @(posedge clk);
    #1;
    launch(0, 16'h0000, 16'h0000, R_EQ, 4, "post_rst");
    finish_cmp("post_rst");
    drain("post_rst", 0, R_EQ);

    // Back-to-back: restart during the done cycle.
    launch(0, 16'h0005, 16'h0005, R_EQ, 4, "b2b_a");
    finish_cmp("b2b_a");
    launch(0, 16'h0003, 16'h0007, R_LT, 4, "b2b_b");
    chk("b2b_done_low", int'(done_v[0]), 0);
    finish_cmp("b2b_b");
    drain("b2b_b", 0, R_LT);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
